// File: rtl/fpu_pkg.sv
// Shared FP32 types and constants for the adder writeback path.
package fpu_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } fp32_t;

    typedef struct packed {
        logic of;
        logic uf;
    } fpu_flags_t;

    localparam logic [7:0]  FP32_EXP_MAX = 8'hFF;
    localparam logic [30:0] FP32_INF_MAG = 31'h7F80_0000;

endpackage

// File: rtl/fpu_wb_fifo.sv
// Generic DEPTH x W synchronous FIFO; owns pointers, occupancy count, full and empty.
module fpu_wb_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 34
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wr_data,
    input  logic         pop,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Storage is not reset; only the bookkeeping decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap by explicit compare so DEPTH need not be a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fpu_add_writeback.sv
// Registered writeback stage for the FP32 adder: saturates at enqueue, buffers in a FIFO.
// Optional sticky CSR flags are built when FPU_WB_STICKY_EN is defined.
module fpu_add_writeback
    import fpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_result,
    input  logic        in_overflow,
    input  logic        in_underflow,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [1:0]  out_flags,
    input  logic        flags_clear,
    output logic [1:0]  sticky_flags
);

    localparam int PTR_W = $clog2(DEPTH);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // ready never depends on valid of the same side, and a full FIFO refuses even while popping.
    fp32_t      raw;
    fp32_t      sat;
    fpu_flags_t in_flags;
    logic       push;
    logic       pop;
    logic       full;
    logic       empty;
    logic [33:0] rd_data;

    assign raw      = fp32_t'(in_result);
    assign in_flags = '{of: in_overflow, uf: in_underflow};

    // Overflow wins when both flags are raised.
    always_comb begin
        sat = raw;
        if (in_overflow) begin
            sat = fp32_t'({raw.sign, FP32_INF_MAG});
        end else if (in_underflow) begin
            sat = fp32_t'({raw.sign, 31'h0});
        end
    end

    assign in_ready = !RST && !full;
    assign push     = in_valid && in_ready;
    assign out_valid = !RST && !empty;
    assign pop      = out_valid && out_ready;

    fpu_wb_fifo #(
        .DEPTH (DEPTH),
        .W     (34)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RST),
        .push    (push),
        .wr_data ({in_flags, sat}),
        .pop     (pop),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty)
    );

    assign out_result = out_valid ? rd_data[31:0]  : 32'h0;
    assign out_flags  = out_valid ? rd_data[33:32] : 2'b00;

`ifdef FPU_WB_STICKY_EN
    // A flag popped in the same cycle as a clear survives.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sticky_flags <= 2'b00;
        end else begin
            sticky_flags <= (flags_clear ? 2'b00 : sticky_flags) | (pop ? out_flags : 2'b00);
        end
    end
`else
    logic unused_flags_clear;
    assign unused_flags_clear = flags_clear;
    assign sticky_flags       = 2'b00;
`endif

    logic [PTR_W-1:0] unused_ptr_w;
    assign unused_ptr_w = '0;

endmodule

// File: tb/tb_fpu_add_writeback.sv
// Scoreboard bench for fpu_add_writeback: saturation, backpressure, wrap, reset, sticky flags.
module tb_fpu_add_writeback;

    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_result = 32'h0;
    logic        in_overflow = 1'b0;
    logic        in_underflow = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [1:0]  out_flags;
    logic        flags_clear = 1'b0;
    logic [1:0]  sticky_flags;

    int n_checks = 0;
    int n_fail   = 0;

    logic [33:0] exp_q[$];
    logic [1:0]  sticky_model = 2'b00;

    fpu_add_writeback #(.DEPTH(DEPTH)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_overflow  (in_overflow),
        .in_underflow (in_underflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_flags    (out_flags),
        .flags_clear  (flags_clear),
        .sticky_flags (sticky_flags)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [33:0] sat_model(input logic [31:0] r, input logic of, input logic uf);
        logic [31:0] v;
        if (of)      v = {r[31], 8'hFF, 23'h0};
        else if (uf) v = {r[31], 31'h0};
        else         v = r;
        return {of, uf, v};
    endfunction

    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        cycle();
        cycle();
        RST = 1'b0;
    endtask

    // Holds in_valid until the stage accepts; leaves in_valid high for back-to-back use.
    task automatic drive(input logic [31:0] r, input logic of, input logic uf);
        logic accepted;
        in_valid     = 1'b1;
        in_result    = r;
        in_overflow  = of;
        in_underflow = uf;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            accepted = in_ready;
            cycle();
            if (accepted) return;
        end
        check("push_timeout", 0, 1);
    endtask

    task automatic idle_in();
        in_valid     = 1'b0;
        in_overflow  = 1'b0;
        in_underflow = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) return;
            cycle();
        end
        check("drain_timeout", exp_q.size(), 0);
    endtask

    // scoreboard: samples on the falling edge, mid-cycle
    always @(negedge CLK) begin
        logic [33:0] e;
        logic        popping;
        check("in_ready", in_ready, !RST && exp_q.size() < DEPTH);
        check("out_valid", out_valid, !RST && exp_q.size() != 0);
        check("sticky", sticky_flags, sticky_model);
        if (RST) begin
            exp_q.delete();
            sticky_model = 2'b00;
        end else begin
            popping = out_valid && out_ready;
            if (popping) begin
                if (exp_q.size() == 0) begin
                    check("pop_when_empty", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", {out_flags, out_result}, e);
                end
            end else if (!out_valid) begin
                check("idle_data", {out_flags, out_result}, 0);
            end
`ifdef FPU_WB_STICKY_EN
            sticky_model = (flags_clear ? 2'b00 : sticky_model) | (popping ? out_flags : 2'b00);
`endif
            if (in_valid && in_ready) begin
                if (exp_q.size() >= DEPTH) check("push_when_full", 1, 0);
                else exp_q.push_back(sat_model(in_result, in_overflow, in_underflow));
            end
        end
    end

    initial begin
        logic [31:0] vals [5];

        do_reset();
        check("reset_out_valid", out_valid, 0);
        check("reset_sticky", sticky_flags, 0);

        // 1: plain value passes through one cycle later
        out_ready = 1'b1;
        drive(32'h3F80_0000, 1'b0, 1'b0);
        idle_in();
        check("t1_valid", out_valid, 1);
        check("t1_result", out_result, 32'h3F80_0000);
        check("t1_flags", out_flags, 2'b00);
        cycle();

        // 2: overflow saturation, then both flags
        drive(32'hBF80_0000, 1'b1, 1'b0);
        check("t2_neg_inf", out_result, 32'hFF80_0000);
        check("t2_of_flags", out_flags, 2'b10);
        drive(32'h1234_5678, 1'b1, 1'b1);
        idle_in();
        check("t2_pos_inf", out_result, 32'h7F80_0000);
        check("t2_both_flags", out_flags, 2'b11);
        cycle();
        wait_drain();

        // 3: backpressure with a fifth value held off
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) vals[i] = $urandom;
        for (int i = 0; i < 4; i++) drive(vals[i], 1'b0, (i == 2));
        check("t3_full_ready", in_ready, 0);
        in_result = vals[4];
        in_overflow = 1'b0;
        in_underflow = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        check("t3_held_ready", in_ready, 0);
        check("t3_head", out_result, vals[0]);
        out_ready = 1'b1;
        drive(vals[4], 1'b0, 1'b0);
        idle_in();
        wait_drain();

        // 4: steady stream at occupancy 2 across pointer wrap
        out_ready = 1'b0;
        drive($urandom, 1'b0, 1'b0);
        drive($urandom, 1'b0, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_result    = $urandom;
            in_overflow  = ($urandom_range(0, 3) == 0);
            in_underflow = ($urandom_range(0, 3) == 0);
            cycle();
            check("t4_occupancy", exp_q.size(), 2);
        end
        idle_in();
        wait_drain();

        // 5: mid-stream reset discards entries
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) drive($urandom, 1'b0, 1'b0);
        idle_in();
        check("t5_pre_valid", out_valid, 1);
        RST = 1'b1;
        cycle();
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_ready", in_ready, 0);
        RST = 1'b0;
        cycle();
        check("t5_post_valid", out_valid, 0);
        drive(32'h4049_0FDB, 1'b0, 1'b0);
        idle_in();
        check("t5_first_head", out_result, 32'h4049_0FDB);
        out_ready = 1'b1;
        cycle();
        check("t5_alone", out_valid, 0);

        // 6: sticky flags
        flags_clear = 1'b1;
        cycle();
        flags_clear = 1'b0;
        drive(32'h0000_0001, 1'b0, 1'b1);
        idle_in();
        cycle();
        check("t6_sticky_uf", sticky_flags, sticky_model);
`ifdef FPU_WB_STICKY_EN
        check("t6_sticky_uf_val", sticky_flags, 2'b01);
`endif
        out_ready = 1'b0;
        drive(32'h7F00_0000, 1'b1, 1'b0);
        idle_in();
        out_ready   = 1'b1;
        flags_clear = 1'b1;
        cycle();
        flags_clear = 1'b0;
        out_ready   = 1'b0;
        check("t6_sticky_set_wins", sticky_flags, sticky_model);
`ifdef FPU_WB_STICKY_EN
        check("t6_sticky_of_val", sticky_flags, 2'b10);
`else
        check("t6_sticky_tied", sticky_flags, 2'b00);
`endif
        cycle();
        wait_drain();
        check("final_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
